// File: rtl/rgb_conv_pkg.sv
// Shared types and constants for the RGB convolution strip sequencer.
package rgb_conv_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLoadW,
    StWpulse,
    StStream,
    StDrain
  } seq_state_e;

  localparam int unsigned DefaultDataWidth = 8;
  localparam int unsigned ResultWidth      = 2 * DefaultDataWidth + 6;
  localparam int unsigned StatsWidth       = 16;

  // 27 products of two DATA_WIDTH values fit in 2*DATA_WIDTH+5 bits; one spare bit kept.
  function automatic int unsigned result_width(input int unsigned dw);
    return 2 * dw + 6;
  endfunction

endpackage

// File: rtl/valid_delay_line.sv
// Fixed-depth 1-bit shift register with asynchronous active-high reset.
module valid_delay_line #(
  parameter int unsigned DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);

  logic [DEPTH-1:0] sr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr_q <= '0;
    end else begin
      sr_q <= (sr_q << 1) | DEPTH'(din);
    end
  end

  assign dout = sr_q[DEPTH-1];

endmodule

// File: rtl/rgb_conv_sequencer.sv
// Strip sequencer for the 3-channel 3x3 systolic convolution array.
// Define SEQ_STATS_EN to build the gap_count/out_count statistics counters.
module rgb_conv_sequencer
  import rgb_conv_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned IMG_WIDTH     = 32,
  parameter int unsigned ARRAY_LATENCY = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         reuse_weights,
  output logic                         busy,
  output logic                         done,
  input  logic                         w_valid,
  output logic                         w_ready,
  input  logic [9*DATA_WIDTH-1:0]      w_r,
  input  logic [9*DATA_WIDTH-1:0]      w_g,
  input  logic [9*DATA_WIDTH-1:0]      w_b,
  input  logic                         col_valid,
  output logic                         col_ready,
  input  logic [3*DATA_WIDTH-1:0]      col_r,
  input  logic [3*DATA_WIDTH-1:0]      col_g,
  input  logic [3*DATA_WIDTH-1:0]      col_b,
  output logic                         arr_load_weight,
  output logic [9*DATA_WIDTH-1:0]      arr_w_r,
  output logic [9*DATA_WIDTH-1:0]      arr_w_g,
  output logic [9*DATA_WIDTH-1:0]      arr_w_b,
  output logic [3*DATA_WIDTH-1:0]      arr_col_r,
  output logic [3*DATA_WIDTH-1:0]      arr_col_g,
  output logic [3*DATA_WIDTH-1:0]      arr_col_b,
  input  logic [2*DATA_WIDTH+5:0]      arr_conv,
  output logic                         out_valid,
  output logic [2*DATA_WIDTH+5:0]      out_data,
  output logic [StatsWidth-1:0]        gap_count,
  output logic [StatsWidth-1:0]        out_count
);

  localparam int unsigned RW        = result_width(DATA_WIDTH);
  localparam int unsigned ColCntW   = $clog2(IMG_WIDTH);
  // Drain covers array latency, the capture register, and the done cycle after it.
  localparam int unsigned DrainLast = ARRAY_LATENCY + 2;
  localparam int unsigned DrainW    = $clog2(DrainLast + 1);

  seq_state_e           state_q, state_d;
  logic [ColCntW-1:0]   col_cnt_q, col_cnt_d;
  logic [1:0]           run_q, run_d;
  logic [DrainW-1:0]    drain_cnt_q, drain_cnt_d;
  logic                 window_q, window_d;
  logic                 accept, load_w, win_out;

  logic [9*DATA_WIDTH-1:0] w_r_q, w_g_q, w_b_q;
  logic [3*DATA_WIDTH-1:0] col_r_q, col_g_q, col_b_q;
  logic                    out_valid_q;
  logic [RW-1:0]           out_data_q;

  always_comb begin
    state_d         = state_q;
    col_cnt_d       = col_cnt_q;
    run_d           = run_q;
    drain_cnt_d     = drain_cnt_q;
    window_d        = 1'b0;
    accept          = 1'b0;
    load_w          = 1'b0;
    w_ready         = 1'b0;
    col_ready       = 1'b0;
    arr_load_weight = 1'b0;
    done            = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          col_cnt_d = '0;
          run_d     = '0;
          state_d   = reuse_weights ? StStream : StLoadW;
        end
      end
      StLoadW: begin
        w_ready = 1'b1;
        if (w_valid) begin
          load_w  = 1'b1;
          state_d = StWpulse;
        end
      end
      StWpulse: begin
        arr_load_weight = 1'b1;
        state_d         = StStream;
      end
      StStream: begin
        col_ready = 1'b1;
        if (col_valid) begin
          accept    = 1'b1;
          col_cnt_d = col_cnt_q + 1'b1;
          run_d     = (run_q == 2'd3) ? 2'd3 : run_q + 2'd1;
          // Window completes when this column makes the contiguous run reach 3.
          window_d  = (run_q >= 2'd2);
          if (col_cnt_q == ColCntW'(IMG_WIDTH - 1)) begin
            drain_cnt_d = '0;
            state_d     = StDrain;
          end
        end else begin
          run_d = '0;
        end
      end
      StDrain: begin
        if (drain_cnt_q == DrainW'(DrainLast)) begin
          done    = 1'b1;
          state_d = StIdle;
        end else begin
          drain_cnt_d = drain_cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      col_cnt_q   <= '0;
      run_q       <= '0;
      drain_cnt_q <= '0;
      window_q    <= 1'b0;
      w_r_q       <= '0;
      w_g_q       <= '0;
      w_b_q       <= '0;
      col_r_q     <= '0;
      col_g_q     <= '0;
      col_b_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      col_cnt_q   <= col_cnt_d;
      run_q       <= run_d;
      drain_cnt_q <= drain_cnt_d;
      window_q    <= window_d;
      if (load_w) begin
        w_r_q <= w_r;
        w_g_q <= w_g;
        w_b_q <= w_b;
      end
      col_r_q     <= accept ? col_r : '0;
      col_g_q     <= accept ? col_g : '0;
      col_b_q     <= accept ? col_b : '0;
      out_valid_q <= win_out;
      if (win_out) begin
        out_data_q <= arr_conv;
      end
    end
  end

  // Delay line output is high the cycle arr_conv reflects the window's newest column.
  valid_delay_line #(
    .DEPTH(ARRAY_LATENCY)
  ) u_win_dly (
    .clk (clk),
    .rst (rst),
    .din (window_q),
    .dout(win_out)
  );

  assign busy      = (state_q != StIdle);
  assign arr_w_r   = w_r_q;
  assign arr_w_g   = w_g_q;
  assign arr_w_b   = w_b_q;
  assign arr_col_r = col_r_q;
  assign arr_col_g = col_g_q;
  assign arr_col_b = col_b_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

`ifdef SEQ_STATS_EN
  logic [StatsWidth-1:0] gap_q, outs_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gap_q  <= '0;
      outs_q <= '0;
    end else if (state_q == StIdle && start) begin
      gap_q  <= '0;
      outs_q <= '0;
    end else begin
      if (state_q == StStream && !col_valid && gap_q != '1) begin
        gap_q <= gap_q + 1'b1;
      end
      if (win_out && outs_q != '1) begin
        outs_q <= outs_q + 1'b1;
      end
    end
  end

  assign gap_count = gap_q;
  assign out_count = outs_q;
`else
  assign gap_count = '0;
  assign out_count = '0;
`endif

endmodule
